// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, legal prescale values,
// parity-type encoding and small helpers used by uart_rx and its sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_type_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Anything outside the legal set falls back to the slowest-to-fastest safe value, 8.
    function automatic logic [5:0] decode_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_16: return PRESCALE_16;
            PRESCALE_32: return PRESCALE_32;
            default:     return PRESCALE_8;
        endcase
    endfunction

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 2-of-3 majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       rx_i,
    input  logic [5:0] prescale_i,
    output logic       bit_o,
    output logic       mid_o,
    output logic       end_o
);

    logic [5:0] cnt_q, cnt_d;
    logic [2:0] smp_q, smp_d;
    logic [5:0] half;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            smp_q <= '1;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    // mid_o fires once all three samples are registered, so bit_o is valid then.
    always_comb begin
        half  = prescale_i >> 1;
        end_o = (cnt_q == prescale_i - 6'd1);
        mid_o = (cnt_q == half + 6'd2);
        bit_o = majority3(smp_q);

        if (clear_i || end_o) cnt_d = '0;
        else                  cnt_d = cnt_q + 6'd1;

        smp_d = smp_q;
        if (cnt_q == half - 6'd1) smp_d[0] = rx_i;
        if (cnt_q == half)        smp_d[1] = rx_i;
        if (cnt_q == half + 6'd1) smp_d[2] = rx_i;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, LSB-first shift register and
// parity/stop checking; bit timing comes from uart_rx_sampler.
module uart_rx
    import uart_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [Width-1:0] P_data,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stop_err
);

    localparam int BitCntW = (Width > 1) ? $clog2(Width) : 1;

    rx_state_e          state_q, state_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [5:0]         presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [Width-1:0]   shreg_q, shreg_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic               par_flag_q, par_flag_d;
    logic [Width-1:0]   p_data_q, p_data_d;
    logic               dv_q, dv_d;
    logic               pe_q, pe_d;
    logic               se_q, se_d;

    logic rx_s, fall, clear, smp_bit, smp_mid, smp_end, last_bit;

    assign rx_s     = sync2_q;
    assign fall     = prev_q & ~rx_s;
    assign last_bit = (bit_cnt_q == BitCntW'(Width - 1));

    uart_rx_sampler u_sampler (
        .clk_i      (CLK),
        .rst_i      (rst),
        .clear_i    (clear),
        .rx_i       (rx_s),
        .prescale_i (presc_q),
        .bit_o      (smp_bit),
        .mid_o      (smp_mid),
        .end_o      (smp_end)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= ST_IDLE;
            presc_q    <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_flag_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            sync1_q    <= RX_IN;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            par_flag_q <= par_flag_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    // Next-state logic. START/STOP leave at mid-bit so glitches and back-to-back edges are handled early.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START: begin
                if (smp_mid && smp_bit) state_d = ST_IDLE;
                else if (smp_end)       state_d = ST_DATA;
            end
            ST_DATA:   if (smp_end && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (smp_end) state_d = ST_STOP;
            ST_STOP:   if (smp_mid) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clear      = (state_q == ST_IDLE);
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_flag_d = par_flag_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    presc_d    = decode_prescale(Prescale);
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    bit_cnt_d  = '0;
                    par_flag_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (smp_end) begin
                    shreg_d   = {smp_bit, shreg_q[Width-1:1]};
                    bit_cnt_d = bit_cnt_q + BitCntW'(1);
                end
            end
            ST_PARITY: begin
                if (smp_end) par_flag_d = (smp_bit != (^shreg_q ^ par_typ_q));
            end
            ST_STOP: begin
                if (smp_mid) begin
                    pe_d = par_flag_q;
                    se_d = ~smp_bit;
                    if (!par_flag_q && smp_bit) begin
                        dv_d     = 1'b1;
                        p_data_d = shreg_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign P_data     = p_data_q;
    assign Data_valid = dv_q;
    assign Par_err    = pe_q;
    assign Stop_err   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frames are serialised by hand
// and the resulting pulses / data are compared against fixed expected values.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_data;
    logic       Data_valid, Par_err, Stop_err;

    int tests_run = 0;
    int tests_failed = 0;

    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;
    logic [7:0] data_log [0:63];

    int b_dv, b_pe, b_se;

    uart_rx #(.Width(8)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_data     (P_data),
        .Data_valid (Data_valid),
        .Par_err    (Par_err),
        .Stop_err   (Stop_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!rst) begin
            if (Data_valid) begin
                data_log[dv_cnt[5:0]] = P_data;
                dv_cnt = dv_cnt + 1;
            end
            if (Par_err)  pe_cnt = pe_cnt + 1;
            if (Stop_err) se_cnt = se_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_dv = dv_cnt;
        b_pe = pe_cnt;
        b_se = se_cnt;
    endtask

    task automatic idle(input int unsigned n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b, input int unsigned p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    // swap: after the start bit, disturb the config inputs to prove they are latched.
    task automatic send_frame(input logic [7:0] d, input int unsigned p, input logic par_on,
                              input logic par_bit, input logic stop_bit, input logic swap);
        send_bit(1'b0, p);
        if (swap) begin
            Prescale = 6'd32;
            PAR_EN   = 1'b1;
            PAR_TYP  = 1'b1;
        end
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (par_on) send_bit(par_bit, p);
        send_bit(stop_bit, p);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_pdata", 32'(P_data), 32'h0);
        chk("reset_dv",    32'(Data_valid), 32'h0);
        chk("reset_pe",    32'(Par_err), 32'h0);
        chk("reset_se",    32'(Stop_err), 32'h0);
        @(negedge CLK);
        rst = 1'b0;
        idle(10);

        // P=8, no parity, 0xA5
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        chk("a5_dv",   32'(dv_cnt - b_dv), 32'd1);
        chk("a5_data", 32'(data_log[b_dv[5:0]]), 32'hA5);
        chk("a5_pe",   32'(pe_cnt - b_pe), 32'd0);
        chk("a5_se",   32'(se_cnt - b_se), 32'd0);

        // P=16, even parity, 0x3C with correct parity 0
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(40);
        chk("3c_dv",   32'(dv_cnt - b_dv), 32'd1);
        chk("3c_data", 32'(data_log[b_dv[5:0]]), 32'h3C);

        // same frame with wrong parity bit 1
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(40);
        chk("3cbad_pe",    32'(pe_cnt - b_pe), 32'd1);
        chk("3cbad_dv",    32'(dv_cnt - b_dv), 32'd0);
        chk("3cbad_pdata", 32'(P_data), 32'h3C);

        // P=32, odd parity, 0x01 parity 0 (correct), stop forced 0
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(80);
        chk("stop_se", 32'(se_cnt - b_se), 32'd1);
        chk("stop_pe", 32'(pe_cnt - b_pe), 32'd0);
        chk("stop_dv", 32'(dv_cnt - b_dv), 32'd0);

        // 3-cycle glitch at P=16, then 0x55
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_bit(1'b0, 3);
        idle(40);
        chk("glitch_dv", 32'(dv_cnt - b_dv), 32'd0);
        chk("glitch_pe", 32'(pe_cnt - b_pe), 32'd0);
        chk("glitch_se", 32'(se_cnt - b_se), 32'd0);
        snap();
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(40);
        chk("55_dv",   32'(dv_cnt - b_dv), 32'd1);
        chk("55_data", 32'(data_log[b_dv[5:0]]), 32'h55);

        // back-to-back 0x12, 0x34 with no idle gap
        snap();
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(40);
        chk("b2b_dv",    32'(dv_cnt - b_dv), 32'd2);
        chk("b2b_data0", 32'(data_log[b_dv[5:0]]), 32'h12);
        chk("b2b_data1", 32'(data_log[6'(b_dv + 1)]), 32'h34);

        // illegal Prescale=5 behaves as 8
        Prescale = 6'd5; PAR_EN = 1'b0;
        snap();
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        chk("p5_dv",   32'(dv_cnt - b_dv), 32'd1);
        chk("p5_data", 32'(data_log[b_dv[5:0]]), 32'h96);

        // config changes mid-frame are ignored
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(40);
        chk("swap_dv",   32'(dv_cnt - b_dv), 32'd1);
        chk("swap_data", 32'(data_log[b_dv[5:0]]), 32'hC3);

        // reset during data bit 4 of 0x7E at P=8
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(1'((8'h7E >> i) & 8'h01), 8);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        rst = 1'b1;
        #1;
        chk("rstmid_pdata", 32'(P_data), 32'h0);
        chk("rstmid_dv",    32'(Data_valid), 32'h0);
        chk("rstmid_pe",    32'(Par_err), 32'h0);
        chk("rstmid_se",    32'(Stop_err), 32'h0);
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        idle(30);
        chk("rstmid_nopulse", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
        snap();
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        chk("7e_dv",   32'(dv_cnt - b_dv), 32'd1);
        chk("7e_data", 32'(data_log[b_dv[5:0]]), 32'h7E);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
